bsram_stream_reader: RTL and testbench

Read-side companion to the boot writer on the 8 KB SDPB BSRAM.
- Owns BSRAM port B (adb/ceb/oce/resetb), sits downstream of the BSRAM and upstream of display/CPU consumers.
- On a start command it streams a contiguous byte range out of BSRAM, handling the BSRAM read latency.
- Data is buffered in a small FIFO and presented on a valid/ready output with full backpressure.

---
 rtl/bsram_stream_reader.sv | 179 +++++++++++++++++
 tb/tb_bsram_stream_reader.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsram_stream_reader.sv
// Streams a contiguous byte range out of BSRAM port B into a small valid/ready FIFO.
// Optional BSRAM_READER_CKSUM_EN adds a running modulo-2^DATA_W checksum output.
module bsram_stream_reader #(
    parameter int ADDR_W     = 13,
    parameter int DATA_W     = 8,
    parameter int READ_LAT   = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              MEMORY_CLK,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] adb,
    output logic              ceb,
    output logic              oce,
    output logic              resetb,
    input  logic [DATA_W-1:0] dout,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready
`ifdef BSRAM_READER_CKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int OCC_W = $clog2(FIFO_DEPTH + READ_LAT + 2) + 1;
    localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t              state_q;
    logic                busy_q, done_q, ceb_q;
    logic [ADDR_W-1:0]   adb_q, rd_addr_q;
    logic [ADDR_W:0]     rem_issue_q, rem_deliver_q;
    logic [READ_LAT-1:0] vld_pipe_q;

    logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]    fifo_cnt_q;

    logic                push, pop, issue, credit_ok;
    logic [OCC_W-1:0]    inflight, occ;

    assign out_valid = (fifo_cnt_q != '0);
    assign out_data  = mem_q[rd_ptr_q];
    assign push      = vld_pipe_q[READ_LAT-1];
    assign pop       = out_valid && out_ready;

    always_comb begin
        inflight = OCC_W'(ceb_q);
        for (int i = 0; i < READ_LAT; i++) begin
            inflight = inflight + OCC_W'(vld_pipe_q[i]);
        end
    end

    // A pop on this edge frees a slot, so a read may be issued against it;
    // this keeps one byte per cycle when FIFO_DEPTH == READ_LAT+2.
    assign occ       = OCC_W'(fifo_cnt_q) + inflight;
    assign credit_ok = occ < (DEPTH_OCC + OCC_W'(pop));
    assign issue     = (state_q == RUN) && (rem_issue_q != '0) && credit_ok;

    always_ff @(posedge MEMORY_CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            ceb_q         <= 1'b0;
            adb_q         <= '0;
            rd_addr_q     <= '0;
            rem_issue_q   <= '0;
            rem_deliver_q <= '0;
        end else begin
            done_q <= 1'b0;
            ceb_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        rd_addr_q     <= base_addr;
                        rem_issue_q   <= length;
                        rem_deliver_q <= length;
                        if (length == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q <= RUN;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (issue) begin
                        ceb_q       <= 1'b1;
                        adb_q       <= rd_addr_q;
                        rd_addr_q   <= rd_addr_q + ADDR_W'(1);
                        rem_issue_q <= rem_issue_q - (ADDR_W+1)'(1);
                        if (rem_issue_q == (ADDR_W+1)'(1)) state_q <= DRAIN;
                    end
                end
                default: ;
            endcase
            // rem_deliver exceeds rem_issue while RUN, so the last hand-off is always in DRAIN
            if (pop) begin
                rem_deliver_q <= rem_deliver_q - (ADDR_W+1)'(1);
                if (rem_deliver_q == (ADDR_W+1)'(1)) begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge MEMORY_CLK or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe_q <= '0;
        end else begin
            vld_pipe_q[0] <= ceb_q;
            for (int i = 1; i < READ_LAT; i++) begin
                vld_pipe_q[i] <= vld_pipe_q[i-1];
            end
        end
    end

    always_ff @(posedge MEMORY_CLK or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= dout;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + CNT_W'(1);
                2'b01:   fifo_cnt_q <= fifo_cnt_q - CNT_W'(1);
                default: ;
            endcase
`ifndef SYNTHESIS
            if (push && !pop) begin
                assert (fifo_cnt_q != DEPTH_CNT)
                    else $error("bsram_stream_reader: push into full fifo");
            end
`endif
        end
    end

`ifdef BSRAM_READER_CKSUM_EN
    logic [DATA_W-1:0] cksum_q;

    always_ff @(posedge MEMORY_CLK or negedge rst_n) begin
        if (!rst_n) begin
            cksum_q <= '0;
        end else if (state_q == IDLE && start) begin
            cksum_q <= '0;
        end else if (pop) begin
            cksum_q <= cksum_q + out_data;
        end
    end

    assign checksum = cksum_q;
`endif

    assign busy   = busy_q;
    assign done   = done_q;
    assign adb    = adb_q;
    assign ceb    = ceb_q;
    assign oce    = busy_q;
    assign resetb = 1'b0;

endmodule

// File: tb/tb_bsram_stream_reader.sv
// Scoreboard bench: two readers (bypass and pipeline BSRAM) share stimulus; a
// negedge monitor pops expected bytes on every handshake.
module tb_bsram_stream_reader;

    localparam int AW    = 13;
    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base = '0;
    logic [AW:0]   len = '0;
    logic          rdy = 1'b0;

    always #5 clk = ~clk;

    logic [DW-1:0] mem [0:8191];

    logic [1:0]         busy_w, done_w, ceb_w, oce_w, resetb_w, vld_w;
    logic [1:0][AW-1:0] adb_w;
    logic [1:0][DW-1:0] dout_w, odata_w;
    logic [DW-1:0]      preg;
`ifdef BSRAM_READER_CKSUM_EN
    logic [1:0][DW-1:0] cks_w;
`endif

    bsram_stream_reader #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(1), .FIFO_DEPTH(DEPTH)) u_lat1 (
        .MEMORY_CLK(clk), .rst_n(rst_n), .start(start), .base_addr(base), .length(len),
        .busy(busy_w[0]), .done(done_w[0]), .adb(adb_w[0]), .ceb(ceb_w[0]), .oce(oce_w[0]),
        .resetb(resetb_w[0]), .dout(dout_w[0]), .out_data(odata_w[0]), .out_valid(vld_w[0]),
        .out_ready(rdy)
`ifdef BSRAM_READER_CKSUM_EN
        , .checksum(cks_w[0])
`endif
    );

    bsram_stream_reader #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(2), .FIFO_DEPTH(DEPTH)) u_lat2 (
        .MEMORY_CLK(clk), .rst_n(rst_n), .start(start), .base_addr(base), .length(len),
        .busy(busy_w[1]), .done(done_w[1]), .adb(adb_w[1]), .ceb(ceb_w[1]), .oce(oce_w[1]),
        .resetb(resetb_w[1]), .dout(dout_w[1]), .out_data(odata_w[1]), .out_valid(vld_w[1]),
        .out_ready(rdy)
`ifdef BSRAM_READER_CKSUM_EN
        , .checksum(cks_w[1])
`endif
    );

    // BSRAM read ports: bypass for instance 0, oce output register for instance 1
    always @(posedge clk) begin
        if (ceb_w[0]) dout_w[0] <= mem[adb_w[0]];
        if (ceb_w[1]) preg <= mem[adb_w[1]];
        if (oce_w[1]) dout_w[1] <= preg;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    logic [DW-1:0] exp0[$];
    logic [DW-1:0] exp1[$];

    int xfer_id = 0;
    int start_edge = 0;
    int cur_x[2], n_iss[2], n_acc[2], max_out[2], n_vld[2], n_busy[2], n_done[2];
    int first_cyc[2], done_cyc[2], last_hs[2], n_adb[2];
    int adb_log[2][4];
    bit stalled[2];
    logic [DW-1:0] held[2];

    always @(negedge clk) begin
        int qs;
        logic [DW-1:0] e;
        for (int i = 0; i < 2; i++) begin
            if (cur_x[i] != xfer_id) begin
                cur_x[i] = xfer_id; n_iss[i] = 0; n_acc[i] = 0; max_out[i] = 0;
                n_vld[i] = 0; n_busy[i] = 0; n_done[i] = 0; first_cyc[i] = -1;
                done_cyc[i] = -1; last_hs[i] = -1; n_adb[i] = 0; stalled[i] = 1'b0;
            end
            if (ceb_w[i]) begin
                if (n_adb[i] < 4) adb_log[i][n_adb[i]] = int'(adb_w[i]);
                n_adb[i]++;
                n_iss[i]++;
                if (n_iss[i] - n_acc[i] > max_out[i]) max_out[i] = n_iss[i] - n_acc[i];
            end
            if (busy_w[i]) n_busy[i]++;
            if (done_w[i]) begin
                n_done[i]++;
                done_cyc[i] = cyc;
                chk($sformatf("busy_low_at_done_lat%0d", i + 1), int'(busy_w[i]), 0);
            end
            if (stalled[i]) begin
                chk($sformatf("stall_hold_lat%0d", i + 1), int'({vld_w[i], odata_w[i]}),
                    int'({1'b1, held[i]}));
                stalled[i] = 1'b0;
            end
            if (vld_w[i]) begin
                n_vld[i]++;
                if (first_cyc[i] < 0) first_cyc[i] = cyc;
                if (!rdy) begin
                    stalled[i] = 1'b1;
                    held[i] = odata_w[i];
                end else begin
                    qs = (i == 0) ? exp0.size() : exp1.size();
                    if (qs == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_extra_lat%0d: got byte %0h, none expected", i + 1, odata_w[i]);
                    end else begin
                        e = (i == 0) ? exp0.pop_front() : exp1.pop_front();
                        chk($sformatf("sb_data_lat%0d", i + 1), int'(odata_w[i]), int'(e));
                    end
                    n_acc[i]++;
                    last_hs[i] = cyc;
                end
            end
        end
    end

    function automatic int outs(input int i);
        return int'({busy_w[i], done_w[i], ceb_w[i], oce_w[i], resetb_w[i], vld_w[i],
                     adb_w[i], odata_w[i]});
    endfunction

    task automatic push_exp(input int v);
        exp0.push_back(DW'(v));
        exp1.push_back(DW'(v));
    endtask

    task automatic do_start(input int b, input int l);
        @(posedge clk);
        #1;
        xfer_id++;
        start = 1'b1;
        base  = AW'(b);
        len   = (AW+1)'(l);
        @(posedge clk);
        #1;
        start_edge = cyc;
        start = 1'b0;
    endtask

    task automatic wait_done(input int mode);
        int k = 0;
        while (!(n_done[0] > 0 && n_done[1] > 0) && k < 3000) begin
            @(posedge clk);
            #1;
            rdy = (mode == 0) || (cyc % 3 == 0);
            k++;
        end
        chk("done_within_budget", int'(n_done[0] > 0 && n_done[1] > 0), 1);
        repeat (6) begin
            @(posedge clk);
            #1;
            rdy = (mode == 0) || (cyc % 3 == 0);
        end
    endtask

    task automatic check_end(input string tag, input int n_bytes);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s_done_once_lat%0d", tag, i + 1), n_done[i], 1);
            chk($sformatf("%s_issued_lat%0d", tag, i + 1), n_iss[i], n_bytes);
            chk($sformatf("%s_credit_lat%0d", tag, i + 1), int'(max_out[i] <= DEPTH), 1);
            chk($sformatf("%s_idle_after_lat%0d", tag, i + 1), int'({busy_w[i], vld_w[i]}), 0);
        end
        chk({tag, "_sb_drained"}, exp0.size() + exp1.size(), 0);
    endtask

    initial begin
        for (int a = 0; a < 8192; a++) mem[a] = '0;
        for (int a = 0; a < 128; a++) mem[12'h200 + a] = DW'(a);
        mem[13'h1FFE] = 8'hA1;
        mem[13'h1FFF] = 8'hA2;
        mem[13'h0000] = 8'hB0;
        mem[13'h0001] = 8'hB1;

        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) chk($sformatf("reset_outs_lat%0d", i + 1), outs(i), 0);
        rst_n = 1'b1;

        // boot pattern, full-rate consumer
        for (int v = 0; v < 128; v++) push_exp(v);
        rdy = 1'b1;
        do_start(12'h200, 128);
        wait_done(0);
        check_end("boot", 128);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("first_valid_edges_lat%0d", i + 1), first_cyc[i] - start_edge, 3 + i);
            chk($sformatf("one_per_cycle_lat%0d", i + 1), last_hs[i] - first_cyc[i], 127);
            chk($sformatf("done_with_last_lat%0d", i + 1), done_cyc[i], last_hs[i] + 1);
            chk($sformatf("busy_seen_lat%0d", i + 1), int'(n_busy[i] > 0), 1);
`ifdef BSRAM_READER_CKSUM_EN
            chk($sformatf("cksum_boot_lat%0d", i + 1), int'(cks_w[i]), 8'hC0);
`endif
        end

        // same transfer, consumer ready one cycle in three
        for (int v = 0; v < 128; v++) push_exp(v);
        rdy = 1'b0;
        do_start(12'h200, 128);
        wait_done(1);
        check_end("stall", 128);

        // address wrap at the top of the array
        rdy = 1'b1;
        push_exp(8'hA1); push_exp(8'hA2); push_exp(8'hB0); push_exp(8'hB1);
        do_start(13'h1FFE, 4);
        wait_done(0);
        check_end("wrap", 4);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("wrap_adb0_lat%0d", i + 1), adb_log[i][0], 13'h1FFE);
            chk($sformatf("wrap_adb1_lat%0d", i + 1), adb_log[i][1], 13'h1FFF);
            chk($sformatf("wrap_adb2_lat%0d", i + 1), adb_log[i][2], 13'h0000);
            chk($sformatf("wrap_adb3_lat%0d", i + 1), adb_log[i][3], 13'h0001);
`ifdef BSRAM_READER_CKSUM_EN
            chk($sformatf("cksum_wrap_lat%0d", i + 1), int'(cks_w[i]), 8'hA4);
`endif
        end

        // zero length: done only
        do_start(12'h300, 0);
        wait_done(0);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("len0_done_next_cycle_lat%0d", i + 1), done_cyc[i] - start_edge, 0);
            chk($sformatf("len0_done_once_lat%0d", i + 1), n_done[i], 1);
            chk($sformatf("len0_no_busy_lat%0d", i + 1), n_busy[i], 0);
            chk($sformatf("len0_no_ceb_lat%0d", i + 1), n_iss[i], 0);
            chk($sformatf("len0_no_valid_lat%0d", i + 1), n_vld[i], 0);
        end

        // start while busy is ignored
        for (int v = 0; v < 4; v++) push_exp(v);
        do_start(12'h200, 4);
        start = 1'b1;
        base  = AW'(12'h240);
        len   = (AW+1)'(10);
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(0);
        check_end("busy_start", 4);

        // abort by reset after 5 bytes
        for (int v = 0; v < 20; v++) push_exp(v);
        rdy = 1'b1;
        do_start(12'h200, 20);
        begin
            int k = 0;
            while (n_acc[1] < 5 && k < 500) begin
                @(posedge clk);
                #1;
                k++;
            end
        end
        chk("abort_after_5", n_acc[1], 5);
        chk("abort_no_done_yet", n_done[0] + n_done[1], 0);
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) chk($sformatf("abort_outs_lat%0d", i + 1), outs(i), 0);
        exp0.delete();
        exp1.delete();
        xfer_id++;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_no_done_in_reset", n_done[0] + n_done[1], 0);
        rst_n = 1'b1;
        push_exp(0);
        push_exp(1);
        do_start(12'h200, 2);
        wait_done(0);
        check_end("after_abort", 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
